// File: rtl/apb_if.sv
// APB bus bundle between an initiator and a completer.
// The master modport is the initiator's view and the slave modport is the completer's view.
interface apb_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_completer_mem.sv
// APB completer that fronts a DEPTH-word register array.
// Each transfer gets wait_cfg wait states, and addresses outside the array get PSLVERR.
module apb_completer_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int WAIT_W = 4
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic [WAIT_W-1:0] wait_cfg,
  apb_if.slave              bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              write_q, write_d;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              setup_err;
  logic [IDX_W-1:0]  setup_idx;
  logic              ready;

  assign setup_idx = bus.paddr[IDX_W-1:0];
  assign setup_err = ({1'b0, bus.paddr} >= DEPTH_EXT);
  assign ready     = (state_q == ST_ACCESS) && (cnt_q == '0);

  assign bus.pready  = ready;
  assign bus.pslverr = ready & err_q;
  assign bus.prdata  = prdata_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    prdata_d = prdata_q;
    mem_d    = mem_q;

    case (state_q)
      ST_IDLE: begin
        // Only a genuine setup phase starts a transfer; a stray penable is ignored.
        if (bus.psel && !bus.penable) begin
          state_d = ST_ACCESS;
          write_d = bus.pwrite;
          addr_d  = setup_idx;
          wdata_d = bus.pwdata;
          cnt_d   = wait_cfg;
          err_d   = setup_err;
          if (!bus.pwrite) begin
            prdata_d = setup_err ? '0 : mem_q[setup_idx];
          end
        end
      end
      ST_ACCESS: begin
        if (!bus.psel) begin
          state_d = ST_IDLE;
        end else if (bus.penable) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            // Completion edge. Writes commit here so that a read setup on the next edge sees the new data.
            if (write_q && !err_q) begin
              mem_d[addr_q] = wdata_q;
            end
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      prdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      prdata_q <= prdata_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: tb/tb_apb_completer_mem.sv
// Directed bench for apb_completer_mem.
// Inputs are driven on the falling edge, and outputs are sampled on the falling edge.
module tb_apb_completer_mem;
  logic       pclk;
  logic       prst;
  logic [3:0] wait_cfg;
  int         n_checks;
  int         n_fail;

  apb_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_completer_mem #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_W(4)
  ) dut (
    .pclk    (pclk),
    .prst    (prst),
    .wait_cfg(wait_cfg),
    .bus     (bus.slave)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Runs one transfer, starting at a falling edge, and returns at a falling edge with psel low.
  // In the returned wait count, -1 means pready never rose.
  task automatic apb_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic [3:0] wc, input logic scramble,
                          output logic [7:0] rd, output logic er, output int waits);
    bit done;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = w;
    bus.paddr   = a;
    bus.pwdata  = d;
    wait_cfg    = wc;
    @(posedge pclk);
    @(negedge pclk);
    bus.penable = 1'b1;
    if (scramble) begin
      wait_cfg   = 4'd0;
      bus.paddr  = ~a;
      bus.pwdata = ~d;
      bus.pwrite = ~w;
    end
    waits = 0;
    done  = 1'b0;
    rd    = '0;
    er    = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (bus.pready === 1'b1) begin
        rd   = bus.prdata;
        er   = bus.pslverr;
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge pclk);
      @(negedge pclk);
    end
    if (!done) waits = -1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  task automatic test_reset;
    prst = 1'b1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0; wait_cfg = '0;
    repeat (2) @(negedge pclk);
    if (bus.pready !== 1'b0) begin n_fail++; $display("FAIL reset_pready got=%b exp=0", bus.pready); end
    n_checks++;
    if (bus.pslverr !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr got=%b exp=0", bus.pslverr); end
    n_checks++;
    if (bus.prdata !== 8'h00) begin n_fail++; $display("FAIL reset_prdata got=%h exp=00", bus.prdata); end
    n_checks++;
    prst = 1'b0;
    @(negedge pclk);
  endtask

  task automatic test_zero_wait_read;
    logic [7:0] rd; logic er; int wt;
    apb_xfer(1'b0, 8'd5, 8'h00, 4'd0, 1'b0, rd, er, wt);
    if (wt !== 0) begin n_fail++; $display("FAIL zw_read_waits got=%0d exp=0", wt); end
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL zw_read_data got=%h exp=00", rd); end
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL zw_read_err got=%b exp=0", er); end
    n_checks++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] rd; logic er; int wt;
    apb_xfer(1'b1, 8'd3, 8'h2A, 4'd0, 1'b0, rd, er, wt);
    if (wt !== 0) begin n_fail++; $display("FAIL b2b_write_waits got=%0d exp=0", wt); end
    n_checks++;
    apb_xfer(1'b0, 8'd3, 8'h00, 4'd0, 1'b0, rd, er, wt);
    if (wt !== 0) begin n_fail++; $display("FAIL b2b_read_waits got=%0d exp=0", wt); end
    n_checks++;
    if (rd !== 8'h2A) begin n_fail++; $display("FAIL b2b_read_data got=%h exp=2a", rd); end
    n_checks++;
    // A write must not disturb the previously returned read data.
    apb_xfer(1'b1, 8'd4, 8'hE1, 4'd0, 1'b0, rd, er, wt);
    if (bus.prdata !== 8'h2A) begin n_fail++; $display("FAIL prdata_hold got=%h exp=2a", bus.prdata); end
    n_checks++;
  endtask

  task automatic test_wait_states;
    logic [7:0] rd; logic er; int wt;
    apb_xfer(1'b1, 8'd10, 8'h55, 4'd3, 1'b1, rd, er, wt);
    if (wt !== 3) begin n_fail++; $display("FAIL ws_write_waits got=%0d exp=3", wt); end
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL ws_write_err got=%b exp=0", er); end
    n_checks++;
    apb_xfer(1'b0, 8'd10, 8'h00, 4'd1, 1'b0, rd, er, wt);
    if (rd !== 8'h55) begin n_fail++; $display("FAIL ws_read_data got=%h exp=55", rd); end
    n_checks++;
    if (wt !== 1) begin n_fail++; $display("FAIL ws_read_waits got=%0d exp=1", wt); end
    n_checks++;
    apb_xfer(1'b0, 8'd4, 8'h00, 4'd15, 1'b0, rd, er, wt);
    if (wt !== 15) begin n_fail++; $display("FAIL ws_max_waits got=%0d exp=15", wt); end
    n_checks++;
    if (rd !== 8'hE1) begin n_fail++; $display("FAIL ws_max_data got=%h exp=e1", rd); end
    n_checks++;
  endtask

  task automatic test_error;
    logic [7:0] rd; logic er; int wt;
    apb_xfer(1'b1, 8'd64, 8'h77, 4'd0, 1'b0, rd, er, wt);
    if (er !== 1'b1) begin n_fail++; $display("FAIL err_write_slverr got=%b exp=1", er); end
    n_checks++;
    apb_xfer(1'b0, 8'd64, 8'h00, 4'd0, 1'b0, rd, er, wt);
    if (er !== 1'b1) begin n_fail++; $display("FAIL err_read_slverr got=%b exp=1", er); end
    n_checks++;
    if (rd !== 8'h00) begin n_fail++; $display("FAIL err_read_data got=%h exp=00", rd); end
    n_checks++;
    apb_xfer(1'b1, 8'd63, 8'hC3, 4'd0, 1'b0, rd, er, wt);
    apb_xfer(1'b0, 8'd63, 8'h00, 4'd0, 1'b0, rd, er, wt);
    if (er !== 1'b0) begin n_fail++; $display("FAIL edge63_slverr got=%b exp=0", er); end
    n_checks++;
    if (rd !== 8'hC3) begin n_fail++; $display("FAIL edge63_data got=%h exp=c3", rd); end
    n_checks++;
    // Address 64 aliases word 0 in its low bits, so word 0 must still be clear.
    apb_xfer(1'b0, 8'd0, 8'h00, 4'd0, 1'b0, rd, er, wt);
    if (rd !== 8'h00) begin n_fail++; $display("FAIL err_no_commit got=%h exp=00", rd); end
    n_checks++;
    apb_xfer(1'b0, 8'd200, 8'h00, 4'd0, 1'b0, rd, er, wt);
    if (er !== 1'b1) begin n_fail++; $display("FAIL err_far_slverr got=%b exp=1", er); end
    n_checks++;
  endtask

  task automatic test_abort;
    logic [7:0] rd; logic er; int wt;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 8'd7; bus.pwdata = 8'h11; wait_cfg = 4'd2;
    @(posedge pclk); @(negedge pclk);
    bus.penable = 1'b1;
    @(posedge pclk); @(negedge pclk);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(posedge pclk); @(negedge pclk);
    if (bus.pready !== 1'b0) begin n_fail++; $display("FAIL abort_pready got=%b exp=0", bus.pready); end
    n_checks++;
    repeat (3) begin @(posedge pclk); @(negedge pclk); end
    apb_xfer(1'b0, 8'd7, 8'h00, 4'd0, 1'b0, rd, er, wt);
    if (rd !== 8'h00) begin n_fail++; $display("FAIL abort_mem7 got=%h exp=00", rd); end
    n_checks++;
  endtask

  task automatic test_violations;
    logic [7:0] rd; logic er; int wt;
    wait_cfg = 4'd0;
    bus.psel = 1'b0; bus.penable = 1'b1; bus.pwrite = 1'b1; bus.paddr = 8'd9; bus.pwdata = 8'h3C;
    @(posedge pclk); @(negedge pclk);
    if (bus.pready !== 1'b0) begin n_fail++; $display("FAIL pen_nosel_pready got=%b exp=0", bus.pready); end
    n_checks++;
    bus.psel = 1'b1;
    @(posedge pclk); @(negedge pclk);
    if (bus.pready !== 1'b0) begin n_fail++; $display("FAIL pen_idle_pready got=%b exp=0", bus.pready); end
    n_checks++;
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge pclk);
    apb_xfer(1'b0, 8'd9, 8'h00, 4'd0, 1'b0, rd, er, wt);
    if (rd !== 8'h00) begin n_fail++; $display("FAIL pen_idle_mem9 got=%h exp=00", rd); end
    n_checks++;
    // With psel high and penable low in ACCESS, the state and the count must both hold.
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 8'd10; wait_cfg = 4'd1;
    repeat (3) begin @(posedge pclk); @(negedge pclk); end
    if (bus.pready !== 1'b0) begin n_fail++; $display("FAIL hold_cnt_pready got=%b exp=0", bus.pready); end
    n_checks++;
    bus.penable = 1'b1;
    @(posedge pclk); @(negedge pclk);
    if (bus.pready !== 1'b1) begin n_fail++; $display("FAIL hold_done_pready got=%b exp=1", bus.pready); end
    n_checks++;
    if (bus.prdata !== 8'h55) begin n_fail++; $display("FAIL hold_done_data got=%h exp=55", bus.prdata); end
    n_checks++;
    @(posedge pclk); @(negedge pclk);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge pclk);
  endtask

  task automatic test_reset_mid_transfer;
    logic [7:0] rd; logic er; int wt;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 8'd20; bus.pwdata = 8'h99; wait_cfg = 4'd0;
    @(posedge pclk); @(negedge pclk);
    bus.penable = 1'b1;
    if (bus.pready !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_pready got=%b exp=1", bus.pready); end
    n_checks++;
    #1 prst = 1'b1;
    #1;
    if (bus.pready !== 1'b0) begin n_fail++; $display("FAIL rmid_pready got=%b exp=0", bus.pready); end
    n_checks++;
    @(posedge pclk); @(negedge pclk);
    prst = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge pclk);
    apb_xfer(1'b0, 8'd20, 8'h00, 4'd0, 1'b0, rd, er, wt);
    if (rd !== 8'h00) begin n_fail++; $display("FAIL rmid_mem20 got=%h exp=00", rd); end
    n_checks++;
    apb_xfer(1'b0, 8'd3, 8'h00, 4'd0, 1'b0, rd, er, wt);
    if (rd !== 8'h00) begin n_fail++; $display("FAIL rmid_mem3_cleared got=%h exp=00", rd); end
    n_checks++;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset;
    test_zero_wait_read;
    test_back_to_back;
    test_wait_states;
    test_error;
    test_abort;
    test_violations;
    test_reset_mid_transfer;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_completer_mem.md
Name: apb_completer_mem

Overview:
- APB completer (slave) holding a small register/memory array.
- Sits on the far side of the team's APB initiator. It answers setup/access phases with a programmable number of wait states, raises PSLVERR for out-of-range addresses, and returns read data.
- Used as the standard bus target for initiator-side integration and regression.

Parameters:
- ADDR_W, 8, width of PADDR.
- DATA_W, 8, width of PWDATA/PRDATA.
- DEPTH, 64, number of implemented words. Valid addresses are 0..DEPTH-1; DEPTH must be ≤ 2^ADDR_W.
- WAIT_W, 4, width of the wait-state configuration input.

Ports:
- pclk  in  1  bus clock; all state changes on the rising edge.
- prst  in  1  asynchronous, active-high reset.
- psel  in  1  completer select.
- penable  in  1  access-phase strobe.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  transfer address.
- pwdata  in  DATA_W  write data.
- wait_cfg  in  WAIT_W  number of wait states to insert per transfer (0 = zero-wait).
- prdata  out  DATA_W  read data; valid while pready=1 on a read.
- pready  out  1  transfer completes on the edge where psel & penable & pready.
- pslverr  out  1  error response; valid only while pready=1.

Behaviour:
- Reset (prst=1, asynchronous):
  - FSM goes to IDLE; wait counter = 0.
  - prdata = 0, pready = 0, pslverr = 0.
  - All DEPTH memory words cleared to 0.
  - Any transfer in flight is abandoned and no write is committed.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On an edge with psel=1 and penable=0 (setup phase), latch the following, then go to ACCESS:
    - pwrite, paddr, pwdata;
    - cnt <= wait_cfg;
    - err_q <= (paddr >= DEPTH);
    - for reads, prdata <= (paddr < DEPTH) ? mem[paddr] : 0.
  - penable=1 while in IDLE (protocol violation) is ignored; the FSM stays in IDLE.
- ACCESS:
  - pready = (state==ACCESS) && (cnt==0). This is a combinational decode of registered state.
  - pslverr = pready & err_q; 0 otherwise.
  - Edge with psel & penable & cnt≠0: cnt <= cnt-1, stay in ACCESS.
  - Edge with psel & penable & cnt==0 (completion):
    - If the latched op is a write and err_q=0, mem[addr_q] <= wdata_q.
    - Erroring writes leave memory unchanged.
    - Go to IDLE.
  - psel=0 while in ACCESS (abort): go to IDLE, no write, no completion.
  - psel=1 with penable=0 while in ACCESS: hold state and hold cnt.
- Latency:
  - A transfer occupies 2 + wait_cfg cycles (setup + wait_cfg wait cycles + 1 ready cycle).
  - Back-to-back transfers: the cycle after completion is IDLE and can itself be a setup cycle, so there is no dead cycle between transfers.
- Latching rules:
  - paddr, pwdata and pwrite changes during ACCESS are ignored.
  - wait_cfg is sampled only at setup.
- prdata holds its value between transfers and updates only at a read setup.
- A write followed immediately by a read to the same address returns the new data, because the write commits before the read's setup edge.
- Address boundaries: DEPTH-1 is a valid address (pslverr=0); DEPTH and above give an error.
- wait_cfg = 2^WAIT_W-1 gives the maximum wait count. The counter never wraps because it stops at 0.

Test Plan:
- Reset then zero-wait read: prst pulse, wait_cfg=0, read addr 5 → pready=1 in the cycle after setup, prdata=0, pslverr=0.
- Zero-wait write/read: write 0x2A to addr 3, then read addr 3 back-to-back with no idle cycle → prdata=0x2A, each transfer takes 2 cycles.
- Wait states: wait_cfg=3, write 0x55 to addr 10 → pready low for 3 access cycles then high for 1. Change wait_cfg to 0 mid-transfer → still 3 wait cycles. Read addr 10 → 0x55.
- Error response: write 0x77 to addr 64 (DEPTH=64) → pslverr=1 with pready. Read addr 64 → prdata=0, pslverr=1. Read addr 63 → pslverr=0.
- Abort and violations:
  - psel deasserted during a wait state of a write to addr 7 → FSM returns to IDLE and mem[7] is unchanged.
  - penable=1 with psel=0, or penable=1 while idle → no state change.
- Reset mid-transfer: prst asserted during the ACCESS phase of a write of 0x99 → pready drops immediately. Read of that address after reset → 0.
